// File: rtl/ws2812b_pixel_feeder.sv
// Byte-bus front end for the WS2812B driver: assembles G,R,B writes into pixels,
// queues them with a repeat count and latch flag, and expands each entry into
// driver handshakes. Define WS2812B_FEEDER_BRIGHTNESS_EN to add a brightness scaler on addr 4.
module ws2812b_pixel_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int REP_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        pix_latch,
  input  logic        pix_ready,
  output logic        fifo_full,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  typedef struct packed {
    logic [23:0]      data;
    logic [REP_W-1:0] rep;
    logic             latch;
  } entry_t;

  state_e           state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       r_q, r_d;
  logic [REP_W-1:0] rep_reg_q, rep_reg_d;
  logic             latch_pending_q, latch_pending_d;
  logic             overflow_q, overflow_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [23:0]      data_q, data_d;
  logic [REP_W-1:0] remaining_q, remaining_d;
  logic             entry_latch_q, entry_latch_d;
  entry_t           fifo_mem_q [FIFO_DEPTH];

  logic       wr_color, push_req, push_ok, flush, pop, handshake;
  logic       fifo_empty, full_now;
  logic [7:0] color_byte;
  entry_t     push_entry, head_entry;

  assign wr_color   = wr_en && (wr_addr == 3'd0);
  assign flush      = wr_en && (wr_addr == 3'd3) && wr_data[0];
  assign push_req   = wr_color && (byte_cnt_q == 2'd2);
  assign fifo_empty = (count_q == '0);
  assign full_now   = (count_q == DEPTH_C);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!full_now || pop);
  assign handshake  = (state_q == SEND) && pix_ready;
  assign head_entry = fifo_mem_q[rd_ptr_q];
  assign push_entry = '{data: {g_q, r_q, color_byte}, rep: rep_reg_q, latch: latch_pending_q};

`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
  logic [7:0] bright_q, bright_d;

  always_comb begin
    bright_d = bright_q;
    if (wr_en && (wr_addr == 3'd4)) bright_d = wr_data;
  end

  assign color_byte = 8'((16'(wr_data) * (16'(bright_q) + 16'd1)) >> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= 8'hFF;
    else        bright_q <= bright_d;
  end
`else
  assign color_byte = wr_data;
`endif

  always_comb begin
    byte_cnt_d      = byte_cnt_q;
    g_d             = g_q;
    r_d             = r_q;
    rep_reg_d       = rep_reg_q;
    latch_pending_d = latch_pending_q;
    overflow_d      = overflow_q;
    if (flush) begin
      byte_cnt_d      = 2'd0;
      latch_pending_d = 1'b0;
      overflow_d      = 1'b0;
    end else begin
      if (wr_color) begin
        case (byte_cnt_q)
          2'd0:    begin g_d = color_byte; byte_cnt_d = 2'd1; end
          2'd1:    begin r_d = color_byte; byte_cnt_d = 2'd2; end
          default: begin
            byte_cnt_d      = 2'd0;
            latch_pending_d = 1'b0;
            if (!push_ok) overflow_d = 1'b1;
          end
        endcase
      end
      if (wr_en && (wr_addr == 3'd1)) rep_reg_d = REP_W'(wr_data);
      if (wr_en && (wr_addr == 3'd2)) latch_pending_d = wr_data[0];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          if (handshake && (remaining_q == '0)) begin
            if (!fifo_empty) pop = 1'b1;
            else             state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d        = data_q;
    remaining_d   = remaining_q;
    entry_latch_d = entry_latch_q;
    if (pop) begin
      data_d        = head_entry.data;
      remaining_d   = head_entry.rep;
      entry_latch_d = head_entry.latch;
    end else if (!flush && handshake && (remaining_q != '0)) begin
      remaining_d = remaining_q - REP_W'(1);
    end
  end

  always_comb begin
    pix_valid = 1'b0;
    pix_latch = 1'b0;
    if (state_q == SEND) begin
      pix_valid = 1'b1;
      pix_latch = entry_latch_q && (remaining_q == '0);
    end
  end

  assign pix_data  = data_q;
  assign fifo_full = full_now;
  assign busy      = !fifo_empty || (state_q == SEND);
  assign overflow  = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q      <= 2'd0;
      g_q             <= 8'd0;
      r_q             <= 8'd0;
      rep_reg_q       <= '0;
      latch_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      data_q          <= 24'd0;
      remaining_q     <= '0;
      entry_latch_q   <= 1'b0;
    end else begin
      byte_cnt_q      <= byte_cnt_d;
      g_q             <= g_d;
      r_q             <= r_d;
      rep_reg_q       <= rep_reg_d;
      latch_pending_q <= latch_pending_d;
      overflow_q      <= overflow_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      data_q          <= data_d;
      remaining_q     <= remaining_d;
      entry_latch_q   <= entry_latch_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_ws2812b_pixel_feeder.sv
// Self-checking bench for ws2812b_pixel_feeder: register-level model of the byte bus
// expands each pushed word into its expected pixel stream, compared at every handshake.
module tb_ws2812b_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_latch;
  logic        pix_ready = 1'b0;
  logic        fifo_full;
  logic        busy;
  logic        overflow;

  typedef struct {
    logic [23:0] data;
    logic        latch;
  } pix_t;

  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  pix_t exp_q[$];
  bit   rand_ready = 1'b0;
  int   model_rep = 0;
  bit   model_latch = 1'b0;
`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
  int   model_bright = 255;
`endif

  pix_t        mon_e;
  bit          stall_prev = 1'b0;
  logic [23:0] prev_data = 24'd0;

  always #5 clk = ~clk;

  ws2812b_pixel_feeder #(.FIFO_DEPTH(4), .REP_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_latch (pix_latch),
    .pix_ready (pix_ready),
    .fifo_full (fifo_full),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Handshake monitor: every accepted pixel must be the next one the model expects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && stall_prev) begin
        checks++;
        if (pix_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL stable_data: pix_data=%h while stalled, required %h", pix_data, prev_data);
        end
      end
      if (pix_valid && pix_ready) begin
        hs_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_pixel: got %h latch=%b, required no pixel", pix_data, pix_latch);
        end else begin
          mon_e = exp_q.pop_front();
          if (pix_data !== mon_e.data || pix_latch !== mon_e.latch) begin
            errors++;
            $display("[TB] FAIL pixel: got %h latch=%b, required %h latch=%b",
                     pix_data, pix_latch, mon_e.data, mon_e.latch);
          end
        end
      end
      stall_prev = pix_valid && !pix_ready;
      prev_data  = pix_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic [7:0] scale(input logic [7:0] b);
`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
    return 8'((int'(b) * (model_bright + 1)) / 256);
`else
    return b;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_rep(input int r);
    wr(3'd1, 8'(r));
    model_rep = r;
  endtask

  task automatic set_latch(input bit l);
    wr(3'd2, {7'd0, l});
    model_latch = l;
  endtask

  task automatic push_word(input logic [23:0] w, input bit dropped);
    pix_t p;
    wr(3'd0, w[23:16]);
    wr(3'd0, w[15:8]);
    wr(3'd0, w[7:0]);
    if (!dropped) begin
      for (int i = 0; i <= model_rep; i++) begin
        p.data  = {scale(w[23:16]), scale(w[15:8]), scale(w[7:0])};
        p.latch = model_latch && (i == model_rep);
        exp_q.push_back(p);
      end
    end
    model_latch = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      errors++;
      $display("[TB] FAIL %s_drain: pending=%0d busy=%b, required pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_data, pix_valid, pix_latch, fifo_full, busy, overflow} !== 29'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: data=%h v=%b l=%b full=%b busy=%b ovf=%b, required all 0",
               pix_data, pix_valid, pix_latch, fifo_full, busy, overflow);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    set_rep(0);
    pix_ready = 1'b1;
    push_word(24'h123456, 1'b0);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_latency_n1: pix_valid=%b, required 0", pix_valid);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'h123456 || pix_latch !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_latency_n2: v=%b data=%h l=%b, required v=1 data=123456 l=0",
               pix_valid, pix_data, pix_latch);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done: v=%b busy=%b, required 0 0", pix_valid, busy);
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_repeat();
    int hs0;
    int c = 0;
    set_rep(3);
    set_latch(1'b1);
    pix_ready = 1'b0;
    hs0 = hs_count;
    push_word(24'hFF0000, 1'b0);
    while ((exp_q.size() != 0 || busy) && c < 400) begin
      pix_ready = (c % 30 == 29);
      tick();
      c++;
    end
    pix_ready = 1'b0;
    checks++;
    if (hs_count - hs0 != 4) begin
      errors++;
      $display("[TB] FAIL repeat_count: handshakes=%0d, required 4", hs_count - hs0);
    end
    set_rep(0);
    pix_ready = 1'b1;
    push_word(24'h00FF00, 1'b0);
    wait_drain(50, "repeat_next");
    pix_ready = 1'b0;
  endtask

  task automatic test_overflow();
    pix_ready = 1'b0;
    set_rep(0);
    for (int i = 0; i < 5; i++) push_word(24'h100000 + 24'(i), 1'b0);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill: full=%b ovf=%b, required 1 0", fifo_full, overflow);
    end
    push_word(24'hDEAD00, 1'b1);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: full=%b ovf=%b, required 1 1", fifo_full, overflow);
    end
    pix_ready = 1'b1;
    wait_drain(100, "overflow");
    checks++;
    if (overflow !== 1'b1 || fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: ovf=%b full=%b, required 1 0", overflow, fifo_full);
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_flush();
    pix_ready = 1'b0;
    push_word(24'h0000AA, 1'b0);
    push_word(24'h0000BB, 1'b0);
    set_latch(1'b1);
    wr(3'd0, 8'hEE);
    wr(3'd3, 8'h01);
    exp_q.delete();
    model_latch = 1'b0;
    checks++;
    if (fifo_full !== 1'b0 || overflow !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush: full=%b ovf=%b v=%b busy=%b, required all 0", fifo_full, overflow, pix_valid, busy);
    end
    pix_ready = 1'b1;
    push_word(24'h0A0B0C, 1'b0);
    wait_drain(50, "flush_after");
    pix_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    pix_ready = 1'b0;
    set_rep(0);
    push_word(24'hA1A2A3, 1'b0);
    push_word(24'hB1B2B3, 1'b0);
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'hA1A2A3) begin
      errors++;
      $display("[TB] FAIL b2b_first: v=%b data=%h, required 1 a1a2a3", pix_valid, pix_data);
    end
    pix_ready = 1'b1;
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'hB1B2B3) begin
      errors++;
      $display("[TB] FAIL b2b_second: v=%b data=%h, required 1 b1b2b3", pix_valid, pix_data);
    end
    tick();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: v=%b, required 0", pix_valid);
    end
    pix_ready = 1'b0;
    wait_drain(20, "b2b");
  endtask

  task automatic test_brightness();
    pix_ready = 1'b1;
    set_rep(0);
`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
    wr(3'd4, 8'd127);
    model_bright = 127;
    push_word(24'hFF8002, 1'b0);
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'h7F4001) begin
      errors++;
      $display("[TB] FAIL brightness: v=%b data=%h, required 1 7f4001", pix_valid, pix_data);
    end
`else
    wr(3'd4, 8'd0);
    push_word(24'hFF8002, 1'b0);
    tick();
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 24'hFF8002) begin
      errors++;
      $display("[TB] FAIL addr4_ignored: v=%b data=%h, required 1 ff8002", pix_valid, pix_data);
    end
`endif
    wait_drain(20, "brightness");
    pix_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    pix_ready = 1'b0;
    set_rep(2);
    push_word(24'h334455, 1'b0);
    tick();
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: v=%b, required 1", pix_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || fifo_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: v=%b busy=%b full=%b, required 0 0 0", pix_valid, busy, fifo_full);
    end
    exp_q.delete();
    model_rep   = 0;
    model_latch = 1'b0;
`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
    model_bright = 255;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    pix_ready = 1'b1;
    push_word(24'h665544, 1'b0);
    wait_drain(50, "reset_mid_fresh");
    pix_ready = 1'b0;
  endtask

  task automatic test_random();
    int n;
    rand_ready = 1'b1;
    for (int round = 0; round < 8; round++) begin
`ifdef WS2812B_FEEDER_BRIGHTNESS_EN
      model_bright = $urandom_range(0, 255);
      wr(3'd4, 8'(model_bright));
`endif
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        set_rep($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) set_latch(1'b1);
        push_word(24'($urandom), 1'b0);
      end
      wait_drain(500, "random");
    end
    rand_ready = 1'b0;
    pix_ready  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_brightness();
    test_reset_mid_send();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
